// File: rtl/nibble_serial_adder_ctrl.sv
// Purpose: W-bit add (optional subtract, SERIAL_ADD_SUB_EN) through one shared 4-bit adder slice, LS nibble first.
// Latency: NIBBLES edges from the accepting edge to the single-cycle done pulse; one result per NIBBLES+1 cycles.
// Backpressure: start is honoured only in IDLE/DONE; a start seen during RUN is dropped, never queued.
module nibble_serial_adder_ctrl #(
    parameter int  NIBBLES = 4,
    localparam int W       = 4 * NIBBLES,
    localparam int IW      = $clog2(NIBBLES + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  ra, rb, rs;
    logic          c;
    logic [IW-1:0] idx;
    logic          a_msb, b_msb;
    logic          load, shift, last;
    logic [W-1:0]  b_ld;
    logic          c_ld;
    logic [4:0]    slice;
    logic [W+3:0]  rs_cat;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is A + ~B + 1; cin is ignored in that case.
    assign b_ld = sub ? ~b : b;
    assign c_ld = sub ? 1'b1 : cin;
`else
    assign b_ld = b;
    assign c_ld = cin;
`endif

    // The one shared adder slice; works on the low nibble of the shifting operands.
    assign slice  = {1'b0, ra[3:0]} + {1'b0, rb[3:0]} + {4'b0000, c};
    // Concatenate then drop the low nibble so the shift is valid even when W == 4.
    assign rs_cat = {slice[3:0], rs};
    assign last   = (idx == IW'(NIBBLES - 1));

    assign sum  = rs;
    assign cout = c;
    // Signed overflow: operands agree in sign but the result does not.
    assign ovf  = (a_msb == b_msb) && (rs[W-1] != a_msb);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode plus handshake outputs and datapath strobes.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                shift = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand/result shift registers, inter-nibble carry and nibble counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ra    <= '0;
            rb    <= '0;
            rs    <= '0;
            c     <= 1'b0;
            idx   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (load) begin
            ra    <= a;
            rb    <= b_ld;
            rs    <= '0;
            c     <= c_ld;
            idx   <= '0;
            a_msb <= a[W-1];
            b_msb <= b_ld[W-1];
        end else if (shift) begin
            rs    <= rs_cat[W+3:4];
            ra    <= ra >> 4;
            rb    <= rb >> 4;
            c     <= slice[4];
            idx   <= idx + IW'(1);
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Purpose: randomized + directed bench for nibble_serial_adder_ctrl with a queue scoreboard.
// Latency: expects done exactly NIBBLES edges after each accepting edge.
// Backpressure: driver issues only when busy is low; mid-RUN starts must produce nothing.
module tb_nibble_serial_adder_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int unsigned  t_acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    int unsigned  cyc = 0;
    int unsigned  busy_run = 0;
    int           n_tests = 0;
    int           n_fail = 0;
    exp_t         sb[$];

    nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    // Reference: whole-word modular arithmetic straight from the operand values.
    function automatic exp_t model(logic [W-1:0] ma, logic [W-1:0] mb, logic mc, logic ms);
        exp_t         e;
        logic [W-1:0] be;
        logic [W:0]   full;
        be     = ms ? ~mb : mb;
        full   = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, (ms ? 1'b1 : mc)};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (ma[W-1] == be[W-1]) && (full[W-1] != ma[W-1]);
        e.t_acc = 0;
        return e;
    endfunction

    // Monitor: every done pulse pops one expectation and checks result and timing.
    always @(negedge clk) begin
        exp_t e;
        if (busy) begin
            busy_run = busy_run + 1;
        end else if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("sum", 64'(sum), 64'(e.sum));
                chk("cout", 64'(cout), 64'(e.cout));
                chk("ovf", 64'(ovf), 64'(e.ovf));
                chk("done_latency", 64'(cyc - e.t_acc), 64'(NIBBLES));
                chk("busy_cycles", 64'(busy_run), 64'(NIBBLES));
            end
            busy_run = 0;
        end else begin
            busy_run = 0;
        end
    end

    // Called at a negedge with the DUT in IDLE/DONE; returns at the next negedge.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc, input logic ts);
        exp_t e;
        a     = ta;
        b     = tb_v;
        cin   = tc;
`ifdef SERIAL_ADD_SUB_EN
        sub   = ts;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        e       = model(ta, tb_v, tc, sub);
        e.t_acc = cyc;
        sb.push_back(e);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
        sub   = ~ts;
`endif
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("wait_done_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("wait_idle_timeout", 64'(1), 64'(0));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Directed adds.
        issue(W'(16'h1234), W'(16'h0FCD), 1'b0, 1'b0); wait_done();
        issue(W'(16'hFFFF), W'(16'h0001), 1'b0, 1'b0); wait_done();
        issue(W'(16'h7FFF), W'(16'h0001), 1'b0, 1'b0); wait_done();

        // Back-to-back: second start presented during DONE.
        issue(W'(16'h4321), W'(16'h1111), 1'b0, 1'b0); wait_done();
        issue(W'(16'h0001), W'(16'h0001), 1'b1, 1'b0); wait_done();

        // Start pulse mid-RUN must be ignored.
        @(negedge clk);
        issue(W'(16'hABCD), W'(16'h1357), 1'b1, 1'b0);
        if (NIBBLES > 1) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();
        repeat (NIBBLES + 2) @(negedge clk);

        // Reset during the 2nd RUN cycle aborts the operation.
        issue(W'(16'h1234), W'(16'h0FCD), 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_sum", 64'(sum), 64'(0));
        chk("abort_cout", 64'(cout), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        issue(W'(16'h1234), W'(16'h0FCD), 1'b0, 1'b0); wait_done();

`ifdef SERIAL_ADD_SUB_EN
        issue(W'(16'h0005), W'(16'h0007), 1'b0, 1'b1); wait_done();
        issue(W'(16'h8000), W'(16'h0001), 1'b0, 1'b1); wait_done();
`endif

        // Random traffic with random gaps (gap 0 means back-to-back from DONE).
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra_v, rb_v;
            logic         rc_v, rs_v;
            ra_v = W'($urandom);
            rb_v = W'($urandom);
            rc_v = 1'($urandom);
            rs_v = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            rs_v = 1'($urandom);
`endif
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(ra_v, rb_v, rc_v, rs_v);
        end
        wait_idle();
        repeat (NIBBLES + 3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
